// File: rtl/min_result_dispatcher.sv
// Holds one winning value and offers it to every selected output channel until
// each has accepted it; an empty select mask is dropped with a one-cycle pulse.
module min_result_dispatcher #(
   parameter int DATA_WIDTH    = 8,
   parameter int CHANNEL_COUNT = 6
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [DATA_WIDTH-1:0]               in_data,
   input  logic [CHANNEL_COUNT-1:0]            in_sel,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [DATA_WIDTH*CHANNEL_COUNT-1:0] out_data,
   output logic [CHANNEL_COUNT-1:0]            out_valids,
   input  logic [CHANNEL_COUNT-1:0]            out_readys,
   output logic                                drop_pulse,
   output logic [15:0]                         dispatch_count
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [CHANNEL_COUNT-1:0] pending_q, pending_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic [15:0]              count_q, count_d;
   logic                     drop_q, drop_d;
   logic                     accept;

   assign accept = in_valid && (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         data_q    <= '0;
         count_q   <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         data_q    <= data_d;
         count_q   <= count_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      data_d    = data_q;
      count_d   = count_q;
      drop_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (|in_sel) begin
                  data_d    = in_data;
                  pending_d = in_sel;
                  state_d   = HOLD;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         HOLD: begin
            // Readies on channels that are no longer pending are masked out here.
            pending_d = pending_q & ~out_readys;
            if (pending_d == '0) begin
               state_d = IDLE;
               count_d = count_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, independent of register state.
   assign in_ready       = reset_n && (state_q == IDLE);
   assign out_valids     = reset_n ? pending_q : '0;
   assign drop_pulse     = drop_q;
   assign dispatch_count = count_q;

   always_comb begin
      out_data = '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
         out_data[i*DATA_WIDTH +: DATA_WIDTH] = reset_n ? data_q : '0;
      end
   end

endmodule
